// File: rtl/rdma_unpacker.sv
// RDMA header unpacker: 4-beat 32-bit stream -> src/dst/op/counter result.
// Optional keep_slave checking when RDMA_UNPACK_KEEP_CHECK_EN is defined.
module rdma_unpacker #(
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              data_slave,
   input  logic [3:0]               keep_slave,
   input  logic                     valid_slave,
   input  logic                     last_slave,
   output logic                     ready_slave,
   output logic [47:0]              src_address,
   output logic [47:0]              dst_address,
   output logic                     operation,
   output logic [30:0]              counter,
   output logic                     valid_master,
   input  logic                     ready_master,
   output logic                     err_frame,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   typedef enum logic [1:0] {
      RECV  = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [1:0]               r_beat;
   logic [47:0]              r_sh_src;
   logic [47:0]              r_sh_dst;
   logic [47:0]              r_src;
   logic [47:0]              r_dst;
   logic                     r_op;
   logic [30:0]              r_cnt;
   logic                     r_valid;
   logic                     r_err;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

   logic [31:0]              w_word;
   logic                     w_ready;
   logic                     w_acc;
   logic                     w_recv_acc;
   logic                     w_beat3;
   logic                     w_bad;
   logic                     w_commit;
   logic                     w_drop;

   assign w_word = {data_slave[7:0], data_slave[15:8],
                    data_slave[23:16], data_slave[31:24]};

   assign w_acc      = valid_slave & w_ready;
   assign w_recv_acc = w_acc & (r_state == RECV);
   assign w_beat3    = (r_beat == 2'd3);

`ifdef RDMA_UNPACK_KEEP_CHECK_EN
   logic r_bad;

   assign w_bad = r_bad | (keep_slave != 4'hf);

   // Bad-keep flag lives for one frame; cleared at every frame end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bad <= 1'b0;
      end else if (w_recv_acc) begin
         r_bad <= (w_beat3 | last_slave) ? 1'b0 : w_bad;
      end
   end
`else
   logic w_unused_keep;

   assign w_unused_keep = ^keep_slave;
   assign w_bad         = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RECV;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         RECV: begin
            if (w_commit) begin
               w_next = HOLD;
            end else if (w_drop && !last_slave) begin
               w_next = DRAIN;
            end
         end
         DRAIN: begin
            if (w_acc && last_slave) begin
               w_next = RECV;
            end
         end
         HOLD: begin
            if (ready_master) begin
               w_next = RECV;
            end
         end
         default: w_next = RECV;
      endcase
   end

   // Output / control decode
   always_comb begin
      w_ready  = (r_state != HOLD);
      w_commit = 1'b0;
      w_drop   = 1'b0;
      if (w_recv_acc) begin
         if (w_beat3) begin
            w_commit = last_slave & ~w_bad;
            w_drop   = ~w_commit;
         end else begin
            w_drop   = last_slave;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat <= 2'd0;
      end else if (w_recv_acc) begin
         r_beat <= (w_beat3 | last_slave) ? 2'd0 : r_beat + 2'd1;
      end else if (r_state != RECV) begin
         r_beat <= 2'd0;
      end
   end

   // Shadow capture; beat 3 fields go straight to the outputs on commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_src <= '0;
         r_sh_dst <= '0;
      end else if (w_recv_acc) begin
         unique case (1'b1)
            (r_beat == 2'd0): r_sh_src[47:16] <= w_word;
            (r_beat == 2'd1): begin
               r_sh_src[15:0]  <= w_word[31:16];
               r_sh_dst[47:32] <= w_word[15:0];
            end
            (r_beat == 2'd2): r_sh_dst[31:0] <= w_word;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_src <= '0;
         r_dst <= '0;
         r_op  <= 1'b0;
         r_cnt <= '0;
      end else if (w_commit) begin
         r_src <= r_sh_src;
         r_dst <= r_sh_dst;
         r_op  <= w_word[31];
         r_cnt <= w_word[30:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
      end else if (w_commit) begin
         r_valid <= 1'b1;
      end else if (r_state == HOLD && ready_master) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= w_drop;
         if (w_drop && (r_err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign ready_slave  = w_ready;
   assign src_address  = r_src;
   assign dst_address  = r_dst;
   assign operation    = r_op;
   assign counter      = r_cnt;
   assign valid_master = r_valid;
   assign err_frame    = r_err;
   assign err_count    = r_err_cnt;

endmodule

// File: tb/tb_rdma_unpacker.sv
// Randomized bench for rdma_unpacker: frames are packed from random fields
// and results/drops are checked against a frame-level model.
module tb_rdma_unpacker;

   typedef struct packed {
      logic [47:0] src;
      logic [47:0] dst;
      logic        op;
      logic [30:0] cnt;
   } res_t;

`ifdef RDMA_UNPACK_KEEP_CHECK_EN
   localparam bit KEEP_EN = 1'b1;
`else
   localparam bit KEEP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_slave;
   logic [3:0]  keep_slave;
   logic        valid_slave;
   logic        last_slave;
   logic        ready_slave;
   logic [47:0] src_address;
   logic [47:0] dst_address;
   logic        operation;
   logic [30:0] counter;
   logic        valid_master;
   logic        ready_master;
   logic        err_frame;
   logic [15:0] err_count;

   logic        s_ready_slave;
   logic [47:0] s_src;
   logic [47:0] s_dst;
   logic        s_op;
   logic [30:0] s_cnt;
   logic        s_valid;
   logic        s_err;
   logic [1:0]  s_err_count;

   int   n_checks = 0;
   int   n_fail = 0;
   int   err_pulses = 0;
   int   exp_err = 0;
   res_t got[$];

   always #5 clk = ~clk;

   rdma_unpacker dut (
      .clk(clk), .rst(rst),
      .data_slave(data_slave), .keep_slave(keep_slave),
      .valid_slave(valid_slave), .last_slave(last_slave),
      .ready_slave(ready_slave),
      .src_address(src_address), .dst_address(dst_address),
      .operation(operation), .counter(counter),
      .valid_master(valid_master), .ready_master(ready_master),
      .err_frame(err_frame), .err_count(err_count)
   );

   rdma_unpacker #(.ERR_CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst(rst),
      .data_slave(data_slave), .keep_slave(keep_slave),
      .valid_slave(valid_slave), .last_slave(last_slave),
      .ready_slave(s_ready_slave),
      .src_address(s_src), .dst_address(s_dst),
      .operation(s_op), .counter(s_cnt),
      .valid_master(s_valid), .ready_master(ready_master),
      .err_frame(s_err), .err_count(s_err_count)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (valid_master && ready_master)
            got.push_back({src_address, dst_address, operation, counter});
         if (err_frame)
            err_pulses++;
      end
   end

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic res_t rand_res();
      res_t r;
      r.src = {16'($urandom), 32'($urandom)};
      r.dst = {16'($urandom), 32'($urandom)};
      r.op  = 1'($urandom);
      r.cnt = 31'($urandom);
      return r;
   endfunction

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   function automatic int sat2(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic send_beat(input logic [31:0] w, input logic [3:0] k,
                            input logic l);
      bit acc;
      bit done = 0;
      data_slave  = bswap(w);
      keep_slave  = k;
      last_slave  = l;
      valid_slave = 1'b1;
      for (int n = 0; n < 40; n++) begin
         acc = ready_slave;
         @(posedge clk);
         #1;
         if (acc) begin
            done = 1;
            break;
         end
      end
      valid_slave = 1'b0;
      last_slave  = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL beat_timeout: ready_slave stayed %b, want 1", ready_slave);
      end
   endtask

   // Sends a frame built with the packer's encoding; updates the model.
   task automatic send_frame(input res_t f, input int nbeats, input int badk);
      logic [31:0] w [4];
      bit bad;
      w[0] = f.src[47:16];
      w[1] = {f.src[15:0], f.dst[47:32]};
      w[2] = f.dst[31:0];
      w[3] = {f.op, f.cnt};
      for (int i = 0; i < nbeats; i++)
         send_beat((i < 4) ? w[i] : $urandom(),
                   (i == badk) ? 4'h7 : 4'hf, i == nbeats - 1);
      bad = (nbeats != 4) || (KEEP_EN && badk >= 0 && badk < 4);
      if (bad) exp_err++;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      valid_slave  = 1'b0;
      last_slave   = 1'b0;
      data_slave   = '0;
      keep_slave   = 4'hf;
      ready_master = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (valid_master !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_valid: got %b want 0", valid_master);
      end
      n_checks++;
      if (ready_slave !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_ready: got %b want 1", ready_slave);
      end
      n_checks++;
      if (err_frame !== 1'b0 || err_count !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_err: got %b/%0d want 0/0", err_frame, err_count);
      end
      n_checks++;
      if ({src_address, dst_address, operation, counter} !== 128'd0) begin
         n_fail++;
         $display("FAIL rst_fields: got %h %h %b %h want 0",
                  src_address, dst_address, operation, counter);
      end
   endtask

   task automatic test_good();
      res_t f;
      res_t r;
      for (int i = 0; i < 10; i++) begin
         if (i == 0) f = {48'h112233445566, 48'hAABBCCDDEEFF, 1'b1, 31'h12345678};
         else f = rand_res();
         send_frame(f, 4, -1);
         n_checks++;
         if (got.size() != 1) begin
            n_fail++;
            $display("FAIL good_count[%0d]: got %0d results want 1", i, got.size());
         end else begin
            r = got.pop_front();
            if (r !== f) begin
               n_fail++;
               $display("FAIL good_fields[%0d]: got %h want %h", i, r, f);
            end
         end
         got.delete();
         n_checks++;
         if (err_count !== 16'(sat16(exp_err))) begin
            n_fail++;
            $display("FAIL good_errcnt[%0d]: got %0d want %0d", i, err_count, exp_err);
         end
      end
   endtask

   task automatic test_back_to_back();
      res_t a = rand_res();
      res_t b = rand_res();
      res_t r;
      ready_master = 1'b0;
      send_frame(a, 4, -1);
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (ready_slave !== 1'b0 || valid_master !== 1'b1 ||
             {src_address, dst_address, operation, counter} !== a) begin
            n_fail++;
            $display("FAIL hold[%0d]: rdy %b vld %b fields %h want 0 1 %h", c,
                     ready_slave, valid_master,
                     {src_address, dst_address, operation, counter}, a);
         end
         @(posedge clk);
         #1;
      end
      ready_master = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (valid_master !== 1'b0 || ready_slave !== 1'b1) begin
         n_fail++;
         $display("FAIL release: vld %b rdy %b want 0 1", valid_master, ready_slave);
      end
      send_frame(b, 4, -1);
      n_checks++;
      if (got.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d want 2", got.size());
      end else begin
         r = got.pop_front();
         if (r !== a) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want %h", r, a);
         end
         n_checks++;
         r = got.pop_front();
         if (r !== b) begin
            n_fail++;
            $display("FAIL b2b_second: got %h want %h", r, b);
         end
      end
      got.delete();
   endtask

   task automatic test_malformed(input int nbeats, input string tag);
      int   e0 = err_pulses;
      res_t f = rand_res();
      res_t g = rand_res();
      res_t r;
      send_frame(f, nbeats, -1);
      n_checks++;
      if (got.size() != 0 || err_pulses - e0 != 1) begin
         n_fail++;
         $display("FAIL %s_drop: results %0d pulses %0d want 0 1", tag,
                  got.size(), err_pulses - e0);
      end
      n_checks++;
      if (err_count !== 16'(sat16(exp_err))) begin
         n_fail++;
         $display("FAIL %s_errcnt: got %0d want %0d", tag, err_count, exp_err);
      end
      got.delete();
      send_frame(g, 4, -1);
      n_checks++;
      if (got.size() != 1) begin
         n_fail++;
         $display("FAIL %s_next: got %0d results want 1", tag, got.size());
      end else begin
         r = got.pop_front();
         if (r !== g) begin
            n_fail++;
            $display("FAIL %s_next_fields: got %h want %h", tag, r, g);
         end
      end
      got.delete();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 5; i++) send_frame(rand_res(), 1 + i % 3, -1);
      n_checks++;
      if (s_err_count !== 2'(sat2(exp_err))) begin
         n_fail++;
         $display("FAIL sat_cnt: got %0d want %0d", s_err_count, sat2(exp_err));
      end
      n_checks++;
      if (err_count !== 16'(sat16(exp_err))) begin
         n_fail++;
         $display("FAIL sat_wide: got %0d want %0d", err_count, exp_err);
      end
   endtask

   task automatic test_reset_mid();
      res_t f = rand_res();
      res_t g = rand_res();
      res_t r;
      send_beat(f.src[47:16], 4'hf, 1'b0);
      send_beat({f.src[15:0], f.dst[47:32]}, 4'hf, 1'b0);
      send_beat(f.dst[31:0], 4'hf, 1'b0);
      rst = 1'b1;
      #2;
      n_checks++;
      if ({src_address, dst_address, operation, counter} !== 128'd0 ||
          valid_master !== 1'b0 || err_count !== 16'd0 || s_err_count !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_out: fields %h vld %b err %0d/%0d want 0",
                  {src_address, dst_address, operation, counter},
                  valid_master, err_count, s_err_count);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_err = 0;
      got.delete();
      send_frame(g, 4, -1);
      n_checks++;
      if (got.size() != 1) begin
         n_fail++;
         $display("FAIL midrst_count: got %0d want 1", got.size());
      end else begin
         r = got.pop_front();
         if (r !== g) begin
            n_fail++;
            $display("FAIL midrst_fields: got %h want %h", r, g);
         end
      end
      got.delete();
   endtask

   task automatic test_keep();
      res_t f = rand_res();
      res_t r;
      int   e0 = err_pulses;
      send_frame(f, 4, 2);
      n_checks++;
      if (got.size() != (KEEP_EN ? 0 : 1) || err_pulses - e0 != (KEEP_EN ? 1 : 0)) begin
         n_fail++;
         $display("FAIL keep_drop: results %0d pulses %0d want %0d %0d",
                  got.size(), err_pulses - e0, KEEP_EN ? 0 : 1, KEEP_EN ? 1 : 0);
      end else if (!KEEP_EN) begin
         r = got.pop_front();
         if (r !== f) begin
            n_fail++;
            $display("FAIL keep_fields: got %h want %h", r, f);
         end
      end
      n_checks++;
      if (err_count !== 16'(sat16(exp_err))) begin
         n_fail++;
         $display("FAIL keep_errcnt: got %0d want %0d", err_count, exp_err);
      end
      got.delete();
   endtask

   task automatic test_random();
      res_t exp_q[$];
      res_t f;
      res_t r;
      int   kind;
      int   nb;
      for (int i = 0; i < 30; i++) begin
         f    = rand_res();
         kind = $urandom_range(0, 3);
         nb   = (kind == 0) ? $urandom_range(1, 3) :
                (kind == 1) ? $urandom_range(5, 7) : 4;
         if (nb == 4) exp_q.push_back(f);
         send_frame(f, nb, -1);
      end
      n_checks++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size());
      end
      while (got.size() > 0 && exp_q.size() > 0) begin
         r = got.pop_front();
         f = exp_q.pop_front();
         n_checks++;
         if (r !== f) begin
            n_fail++;
            $display("FAIL rand_fields: got %h want %h", r, f);
         end
      end
      n_checks++;
      if (err_count !== 16'(sat16(exp_err)) || s_err_count !== 2'(sat2(exp_err))) begin
         n_fail++;
         $display("FAIL rand_errcnt: got %0d/%0d want %0d", err_count,
                  s_err_count, exp_err);
      end
      got.delete();
   endtask

   initial begin
      test_reset();
      test_good();
      test_back_to_back();
      test_malformed(2, "short");
      test_malformed(6, "long");
      test_saturation();
      test_reset_mid();
      test_keep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
